// File: rtl/signed_mul_seq_ctrl.sv
// Sequential Baugh-Wooley signed NxN multiplier: one partial-product row per cycle into a
// carry-save pair, then one ripple add; valid/ready on both sides, N+1 cycles accept-to-valid.
module signed_mul_seq_ctrl #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           flush,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int W  = 2 * N;
  localparam int RW = (N > 2) ? $clog2(N) : 1;
  localparam logic [W-1:0] BW_CONST = (W'(1) << N) | (W'(1) << (W - 1));

  typedef enum logic [1:0] {IDLE, ROW, FINAL, DONE} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row;
  logic [N-1:0]  op_a, op_b;
  logic [W-1:0]  sum_r, carry_r;
  logic [N-1:0]  pp_row;
  logic [W-1:0]  pp_vec, sum_nxt, carry_nxt, final_sum;
  logic          accept, last_row;

  assign accept    = (state == IDLE) && start && !flush;
  assign last_row  = (row == RW'(N - 1));
  assign in_ready  = (state == IDLE);
  assign busy      = (state == ROW) || (state == FINAL);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROW;
      ROW:     if (flush) state_nxt = IDLE;
               else if (last_row) state_nxt = FINAL;
      FINAL:   state_nxt = flush ? IDLE : DONE;
      DONE:    if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edge cells (exactly one index at N-1) carry the inverted partial product.
  always_comb begin
    pp_row = '0;
    for (int j = 0; j < N; j++) begin
      pp_row[j] = (op_a[j] & op_b[row]) ^ ((j == N - 1) != last_row);
    end
    pp_vec    = W'(pp_row) << row;
    sum_nxt   = sum_r ^ carry_r ^ pp_vec;
    carry_nxt = ((sum_r & carry_r) | (sum_r & pp_vec) | (carry_r & pp_vec)) << 1;
    final_sum = sum_r + carry_r + BW_CONST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sum_r   <= '0;
      carry_r <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a    <= a;
          op_b    <= b;
          sum_r   <= '0;
          carry_r <= '0;
          row     <= '0;
        end
        ROW: if (!flush) begin
          sum_r   <= sum_nxt;
          carry_r <= carry_nxt;
          row     <= row + RW'(1);
        end
        FINAL: if (!flush) product <= final_sum;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_mul_seq_ctrl.sv
// Bench for signed_mul_seq_ctrl: directed cases, exhaustive and random operands against
// an integer-multiply reference, backpressure, flush and asynchronous reset.
module tb_signed_mul_seq_ctrl;
  localparam int N = 3;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n, start, flush, out_ready;
  logic [N-1:0] a, b;
  logic         in_ready, busy, out_valid;
  logic [W-1:0] product;

  int errors = 0;
  int checks = 0;

  signed_mul_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready), .a(a), .b(b),
    .flush(flush), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .product(product)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    int sx, sy, p;
    sx = $signed(x);
    sy = $signed(y);
    p  = sx * sy;
    return p[W-1:0];
  endfunction

  // Starts an operation from IDLE and waits for out_valid; leaves the DUT in DONE.
  task automatic launch(input logic [N-1:0] xa, input logic [N-1:0] xb,
                        output logic [W-1:0] res, output int lat, output bit timeout);
    int n;
    timeout = 0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    a = xa; b = xb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    if (!out_valid) timeout = 1;
    res = product;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; flush = 0; out_ready = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid, product} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset: in_ready=%b busy=%b out_valid=%b product=%h, want 1 0 0 00",
               in_ready, busy, out_valid, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [N-1:0] da [4] = '{3'b011, 3'b100, 3'b100, 3'b111};
    logic [N-1:0] db [4] = '{3'b010, 3'b100, 3'b011, 3'b111};
    logic [W-1:0] dp [4] = '{6'b000110, 6'b010000, 6'b110100, 6'b000001};
    logic [W-1:0] res; int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      launch(da[i], db[i], res, lat, to);
      checks++;
      if (to || res !== dp[i]) begin
        errors++;
        $display("FAIL directed[%0d]: product=%b timeout=%0d, want %b", i, res, to, dp[i]);
      end
      checks++;
      if (lat != N + 1) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d edges, want %0d", i, lat, N + 1);
      end
      consume();
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] res; int lat; bit to; int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      launch(i[5:3], i[2:0], res, lat, to);
      checks++;
      if (to || res !== ref_mul(i[5:3], i[2:0]) || lat != N + 1) begin
        errors++; bad++;
        if (bad < 8)
          $display("FAIL sweep a=%0d b=%0d: product=%b lat=%0d, want %b lat=%0d",
                   i[5:3], i[2:0], res, lat, ref_mul(i[5:3], i[2:0]), N + 1);
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] res; int lat; bit to; logic [N-1:0] ra, rb;
    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom;
      launch(ra, rb, res, lat, to);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (to || product !== ref_mul(ra, rb) || !out_valid) begin
        errors++;
        $display("FAIL random a=%0d b=%0d: product=%b valid=%b, want %b valid=1",
                 ra, rb, product, out_valid, ref_mul(ra, rb));
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res, exp; int lat; bit to; int bad;
    exp = ref_mul(3'b101, 3'b011);
    launch(3'b101, 3'b011, res, lat, to);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      if (to || product !== exp || !out_valid || in_ready || busy) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold: %0d unstable cycles, product=%b valid=%b in_ready=%b, want %b 1 0",
               bad, product, out_valid, in_ready, exp);
    end
    consume();
    checks++;
    if (!in_ready || out_valid || product !== exp) begin
      errors++;
      $display("FAIL release: in_ready=%b out_valid=%b product=%b, want 1 0 %b",
               in_ready, out_valid, product, exp);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] prev, res; int lat; bit to; bit rose;
    prev = product;
    a = 3'b010; b = 3'b011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (!in_ready || busy || out_valid || product !== prev) begin
      errors++;
      $display("FAIL flush: in_ready=%b busy=%b valid=%b product=%b, want 1 0 0 %b",
               in_ready, busy, out_valid, product, prev);
    end
    rose = 0;
    repeat (6) begin @(negedge clk); if (out_valid) rose = 1; end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL flush_valid: out_valid rose=1, want 0");
    end
    launch(3'b011, 3'b011, res, lat, to);
    checks++;
    if (to || res !== 6'b001001) begin
      errors++;
      $display("FAIL after_flush: product=%b, want 001001", res);
    end
    // flush in DONE drops the result
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (!in_ready || out_valid) begin
      errors++;
      $display("FAIL flush_done: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] res; int lat; bit to;
    a = 3'b111; b = 3'b101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, out_valid, product} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b busy=%b valid=%b product=%b, want 1 0 0 0",
               in_ready, busy, out_valid, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(3'b101, 3'b010, res, lat, to);
    checks++;
    if (to || res !== 6'b111010) begin
      errors++;
      $display("FAIL after_reset: product=%b, want 111010", res);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_random();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
